// File: rtl/iddmm_pkg.sv
// Shared definitions for the IDDMM result path: default operand geometry and
// the result reader's state encoding.
package iddmm_pkg;

   localparam int unsigned K_DEF = 256;
   localparam int unsigned N_DEF = 16;

   typedef enum logic [1:0] {
      S_FILL  = 2'd0,
      S_DRAIN = 2'd1,
      S_CLEAR = 2'd2
   } state_t;

endpackage

// File: rtl/iddmm_word_buf.sv
// N x K register buffer filled in strict word order by a strobe, with a
// combinational read port and a synchronous pointer clear.
module iddmm_word_buf #(
   parameter int unsigned K      = 256,
   parameter int unsigned N      = 16,
   parameter int unsigned ADDR_W = $clog2(N)
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              wr_en,
   input  logic [K-1:0]      wr_data,
   input  logic              clr,
   input  logic [ADDR_W-1:0] rd_ptr,
   output logic [K-1:0]      rd_data_c,
   output logic              full_next_c,
   output logic              ovf_c
);

   localparam int unsigned WPW = ADDR_W + 1;

   logic [K-1:0]   mem [N];
   logic [WPW-1:0] wp;
   logic           full;

   assign full        = (wp == WPW'(N));
   assign ovf_c       = wr_en & full;
   // Counts a write landing in the same cycle, so a final word coincident with
   // cal_done is seen as a complete buffer.
   assign full_next_c = full | (wr_en & (wp == WPW'(N - 1)));
   assign rd_data_c   = mem[rd_ptr];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wp <= '0;
      end else if (clr) begin
         wp <= '0;
      end else if (wr_en && !full) begin
         wp <= wp + WPW'(1);
      end
   end

   // Data storage carries no reset; contents are only meaningful below wp.
   always_ff @(posedge clk) begin
      if (wr_en && !full && !clr) begin
         mem[wp[ADDR_W-1:0]] <= wr_data;
      end
   end

endmodule

// File: rtl/iddmm_result_reader.sv
// Collects the IDDMM core's unreduced and subtracted result streams and, on
// cal_done, drains the stream chosen by cal_sign as N words, LSW first.
module iddmm_result_reader
   import iddmm_pkg::*;
#(
   parameter int unsigned K      = K_DEF,
   parameter int unsigned N      = N_DEF,
   parameter int unsigned ADDR_W = $clog2(N)
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         fifo_wr_en_a,
   input  logic [K-1:0] fifo_wr_data_a,
   input  logic         fifo_wr_en_sub,
   input  logic [K-1:0] fifo_wr_data_sub,
   input  logic         cal_done,
   input  logic         cal_sign,
   output logic         in_ready,
   output logic         o_valid,
   input  logic         o_ready,
   output logic [K-1:0] o_data,
   output logic         o_last,
   output logic         o_done,
   output logic         o_sel,
   output logic         o_err
);

   state_t            state;
   logic [ADDR_W-1:0] rd_ptr;
   logic              in_fill;
   logic              wr_a;
   logic              wr_sub;
   logic              clr;
   logic              last_word;
   logic              err_set;
   logic [K-1:0]      rd_a;
   logic [K-1:0]      rd_sub;
   logic              full_a;
   logic              full_sub;
   logic              ovf_a;
   logic              ovf_sub;

   assign in_fill   = (state == S_FILL);
   assign clr       = (state == S_CLEAR);
   assign wr_a      = fifo_wr_en_a & in_fill;
   assign wr_sub    = fifo_wr_en_sub & in_fill;
   assign last_word = (rd_ptr == ADDR_W'(N - 1));

   // Overflow, strobes outside FILL, and a cal_done with either buffer short.
   assign err_set = ovf_a | ovf_sub
                  | (~in_fill & (fifo_wr_en_a | fifo_wr_en_sub | cal_done))
                  | (in_fill & cal_done & ~(full_a & full_sub));

   iddmm_word_buf #(.K(K), .N(N), .ADDR_W(ADDR_W)) u_buf_a (
      .clk         (clk),
      .rst_n       (rst_n),
      .wr_en       (wr_a),
      .wr_data     (fifo_wr_data_a),
      .clr         (clr),
      .rd_ptr      (rd_ptr),
      .rd_data_c   (rd_a),
      .full_next_c (full_a),
      .ovf_c       (ovf_a)
   );

   iddmm_word_buf #(.K(K), .N(N), .ADDR_W(ADDR_W)) u_buf_sub (
      .clk         (clk),
      .rst_n       (rst_n),
      .wr_en       (wr_sub),
      .wr_data     (fifo_wr_data_sub),
      .clr         (clr),
      .rd_ptr      (rd_ptr),
      .rd_data_c   (rd_sub),
      .full_next_c (full_sub),
      .ovf_c       (ovf_sub)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state  <= S_FILL;
         rd_ptr <= '0;
         o_sel  <= 1'b0;
         o_err  <= 1'b0;
      end else begin
         if (err_set) o_err <= 1'b1;
         case (state)
            S_FILL: begin
               if (cal_done) begin
                  o_sel  <= cal_sign;
                  rd_ptr <= '0;
                  state  <= S_DRAIN;
               end
            end
            S_DRAIN: begin
               if (o_ready) begin
                  if (last_word) state  <= S_CLEAR;
                  else           rd_ptr <= rd_ptr + ADDR_W'(1);
               end
            end
            S_CLEAR: state <= S_FILL;
            default: state <= S_FILL;
         endcase
      end
   end

   // Handshake outputs decode straight from the state register.
   assign in_ready = in_fill;
   assign o_valid  = (state == S_DRAIN);
   assign o_last   = o_valid & last_word;
   assign o_done   = clr;
   assign o_data   = o_valid ? (o_sel ? rd_sub : rd_a) : '0;

endmodule

// File: tb/tb_iddmm_result_reader.sv
// Randomized self-checking bench for iddmm_result_reader against a word-array
// model of the two result buffers.
module tb_iddmm_result_reader;
   import iddmm_pkg::*;

   localparam int unsigned K = K_DEF;
   localparam int unsigned N = N_DEF;

   logic         clk = 1'b0;
   logic         rst_n;
   logic         fifo_wr_en_a, fifo_wr_en_sub, cal_done, cal_sign, o_ready;
   logic [K-1:0] fifo_wr_data_a, fifo_wr_data_sub, o_data;
   logic         in_ready, o_valid, o_last, o_done, o_sel, o_err;

   int total = 0;
   int bad   = 0;

   logic [K-1:0] ma [N];
   logic [K-1:0] ms [N];
   bit           ka [N];
   bit           ks [N];
   logic [K-1:0] obs_q [$];
   int           last_idx, last_cnt, hold_bad, ir_bad, done_gap, done_cyc;
   logic         ir_after;
   logic [K-1:0] data_after;

   iddmm_result_reader #(.K(K), .N(N)) dut (
      .clk(clk), .rst_n(rst_n),
      .fifo_wr_en_a(fifo_wr_en_a), .fifo_wr_data_a(fifo_wr_data_a),
      .fifo_wr_en_sub(fifo_wr_en_sub), .fifo_wr_data_sub(fifo_wr_data_sub),
      .cal_done(cal_done), .cal_sign(cal_sign), .in_ready(in_ready),
      .o_valid(o_valid), .o_ready(o_ready), .o_data(o_data), .o_last(o_last),
      .o_done(o_done), .o_sel(o_sel), .o_err(o_err)
   );

   always #5 clk = ~clk;

   function automatic logic [K-1:0] rand_word();
      logic [K-1:0] w;
      for (int j = 0; j < int'(K / 32); j++) w[j*32 +: 32] = $urandom;
      return w;
   endfunction

   // Index of the first drained word disagreeing with the model (-1 if none).
   function automatic int first_mismatch(input bit sel);
      for (int i = 0; i < int'(N); i++) begin
         if (i >= obs_q.size()) return i;
         if ((sel ? ks[i] : ka[i]) && obs_q[i] !== (sel ? ms[i] : ma[i])) return i;
      end
      return -1;
   endfunction

   task automatic apply_reset();
      rst_n = 1'b0; fifo_wr_en_a = 0; fifo_wr_en_sub = 0; cal_done = 0; cal_sign = 0;
      o_ready = 1'b1;
      ka = '{default: 1'b0}; ks = '{default: 1'b0};
      repeat (2) @(posedge clk);
      #1 rst_n = 1'b1;
   endtask

   // na a-words, then ns sub-words with cal_done on the last sub write.
   task automatic do_fill(input int na, input int ns, input bit sign, input bit pat);
      for (int i = 0; i < na; i++) begin
         fifo_wr_en_a   = 1'b1;
         fifo_wr_data_a = pat ? K'(32'hA00 + i) : rand_word();
         if (i < int'(N)) begin ma[i] = fifo_wr_data_a; ka[i] = 1'b1; end
         @(posedge clk); #1;
      end
      fifo_wr_en_a = 1'b0;
      for (int i = 0; i < ns; i++) begin
         fifo_wr_en_sub   = 1'b1;
         fifo_wr_data_sub = pat ? K'(32'h500 + i) : rand_word();
         if (i < int'(N)) begin ms[i] = fifo_wr_data_sub; ks[i] = 1'b1; end
         cal_done = (i == ns - 1);
         cal_sign = sign;
         @(posedge clk); #1;
      end
      fifo_wr_en_sub = 1'b0; cal_done = 1'b0;
   endtask

   // Gathers the drain from t+1; mode 0 ready=1, 1 ready 1,0,0 pattern, 2 random.
   task automatic collect(input int mode, input bit inject);
      int cyc, acc_cyc;
      bit stalled;
      logic [K-1:0] pd;
      logic pl;
      obs_q.delete();
      last_idx = -1; last_cnt = 0; hold_bad = 0; ir_bad = 0; done_gap = -1; done_cyc = -1;
      cyc = 0; acc_cyc = -100; stalled = 0; pd = '0; pl = 1'b0;
      while (cyc < 300) begin
         o_ready = (mode == 1) ? (cyc % 3 == 0) : (mode == 2) ? 1'($urandom_range(0, 1)) : 1'b1;
         fifo_wr_en_sub   = inject && (cyc == 2);
         cal_done         = inject && (cyc == 2);
         fifo_wr_data_sub = rand_word();
         if (in_ready !== 1'b0) ir_bad++;
         if (o_done === 1'b1) begin done_gap = cyc - acc_cyc; done_cyc = cyc; break; end
         if (o_valid === 1'b1) begin
            if (stalled && (o_data !== pd || o_last !== pl)) hold_bad++;
            stalled = !o_ready; pd = o_data; pl = o_last;
            if (o_ready) begin
               obs_q.push_back(o_data);
               if (o_last === 1'b1) begin last_idx = obs_q.size() - 1; last_cnt++; end
               acc_cyc = cyc;
            end
         end
         @(posedge clk); #1;
         cyc++;
      end
      fifo_wr_en_sub = 1'b0; cal_done = 1'b0; o_ready = 1'b1;
      @(posedge clk); #1;
      ir_after = in_ready; data_after = o_data;
   endtask

   task automatic test_reset();
      total += 7;
      if (in_ready !== 1'b1) begin bad++; $display("FAIL rst_in_ready got %b want 1", in_ready); end
      if (o_valid !== 1'b0) begin bad++; $display("FAIL rst_o_valid got %b want 0", o_valid); end
      if (o_data !== '0) begin bad++; $display("FAIL rst_o_data got %0h want 0", o_data); end
      if (o_last !== 1'b0) begin bad++; $display("FAIL rst_o_last got %b want 0", o_last); end
      if (o_done !== 1'b0) begin bad++; $display("FAIL rst_o_done got %b want 0", o_done); end
      if (o_sel !== 1'b0) begin bad++; $display("FAIL rst_o_sel got %b want 0", o_sel); end
      if (o_err !== 1'b0) begin bad++; $display("FAIL rst_o_err got %b want 0", o_err); end
   endtask

   task automatic test_select(input bit sign, input bit pat);
      int fm;
      do_fill(N, N, sign, pat);
      collect(0, 1'b0);
      fm = first_mismatch(sign);
      total += 8;
      if (obs_q.size() != int'(N)) begin bad++; $display("FAIL sel%0d_count got %0d want %0d", sign, obs_q.size(), N); end
      if (fm != -1) begin bad++; $display("FAIL sel%0d_word got bad index %0d want -1", sign, fm); end
      if (last_idx != int'(N) - 1 || last_cnt != 1) begin bad++; $display("FAIL sel%0d_last got idx %0d cnt %0d want %0d 1", sign, last_idx, last_cnt, N - 1); end
      if (done_cyc != int'(N)) begin bad++; $display("FAIL sel%0d_done_time got %0d want %0d", sign, done_cyc, N); end
      if (ir_bad != 0 || ir_after !== 1'b1) begin bad++; $display("FAIL sel%0d_in_ready got bad %0d after %b want 0 1", sign, ir_bad, ir_after); end
      if (data_after !== '0) begin bad++; $display("FAIL sel%0d_idle_data got %0h want 0", sign, data_after); end
      if (o_sel !== sign) begin bad++; $display("FAIL sel%0d_o_sel got %b want %b", sign, o_sel, sign); end
      if (o_err !== 1'b0) begin bad++; $display("FAIL sel%0d_o_err got %b want 0", sign, o_err); end
   endtask

   task automatic test_backpressure();
      int fm;
      for (int m = 1; m <= 2; m++) begin
         bit sign;
         sign = 1'($urandom_range(0, 1));
         do_fill(N, N, sign, 1'b0);
         collect(m, 1'b0);
         fm = first_mismatch(sign);
         total += 5;
         if (obs_q.size() != int'(N)) begin bad++; $display("FAIL bp%0d_count got %0d want %0d", m, obs_q.size(), N); end
         if (fm != -1) begin bad++; $display("FAIL bp%0d_word got bad index %0d want -1", m, fm); end
         if (hold_bad != 0) begin bad++; $display("FAIL bp%0d_hold got %0d unstable want 0", m, hold_bad); end
         if (done_gap != 1) begin bad++; $display("FAIL bp%0d_done_gap got %0d want 1", m, done_gap); end
         if (last_idx != int'(N) - 1 || last_cnt != 1) begin bad++; $display("FAIL bp%0d_last got idx %0d cnt %0d want %0d 1", m, last_idx, last_cnt, N - 1); end
      end
   endtask

   task automatic test_back_to_back();
      int fm;
      for (int op = 0; op < 3; op++) begin
         do_fill(N, N, 1'(op), 1'b0);
         collect(0, 1'b0);
         fm = first_mismatch(1'(op));
         total += 2;
         if (fm != -1 || obs_q.size() != int'(N)) begin bad++; $display("FAIL b2b%0d_word got bad index %0d count %0d want -1 %0d", op, fm, obs_q.size(), N); end
         if (o_sel !== 1'(op) || o_err !== 1'b0) begin bad++; $display("FAIL b2b%0d_flags got sel %b err %b want %b 0", op, o_sel, o_err, 1'(op)); end
      end
   endtask

   task automatic test_short_fill();
      int fm;
      do_fill(N, N - 1, 1'b1, 1'b0);
      collect(0, 1'b0);
      fm = first_mismatch(1'b1);
      total += 3;
      if (o_err !== 1'b1) begin bad++; $display("FAIL short_err got %b want 1", o_err); end
      if (obs_q.size() != int'(N)) begin bad++; $display("FAIL short_count got %0d want %0d", obs_q.size(), N); end
      if (fm != -1) begin bad++; $display("FAIL short_stale_word got bad index %0d want -1", fm); end
   endtask

   task automatic test_write_in_drain();
      int fm;
      apply_reset();
      do_fill(N, N, 1'b1, 1'b0);
      collect(0, 1'b1);
      fm = first_mismatch(1'b1);
      total += 2;
      if (o_err !== 1'b1) begin bad++; $display("FAIL wdrain_err got %b want 1", o_err); end
      if (fm != -1 || obs_q.size() != int'(N)) begin bad++; $display("FAIL wdrain_word got bad index %0d count %0d", fm, obs_q.size()); end
      do_fill(N, N, 1'b1, 1'b0);
      collect(0, 1'b0);
      fm = first_mismatch(1'b1);
      total += 1;
      if (fm != -1 || obs_q.size() != int'(N)) begin bad++; $display("FAIL wdrain_next_word got bad index %0d count %0d", fm, obs_q.size()); end
   endtask

   task automatic test_overflow();
      int fm;
      apply_reset();
      do_fill(N + 1, N, 1'b0, 1'b0);
      collect(0, 1'b0);
      fm = first_mismatch(1'b0);
      total += 2;
      if (o_err !== 1'b1) begin bad++; $display("FAIL ovf_err got %b want 1", o_err); end
      if (fm != -1 || obs_q.size() != int'(N)) begin bad++; $display("FAIL ovf_word got bad index %0d count %0d", fm, obs_q.size()); end
   endtask

   task automatic test_reset_mid_drain();
      int done_seen, fm;
      do_fill(N, N, 1'b1, 1'b0);
      o_ready = 1'b1;
      repeat (6) @(posedge clk);
      #1 rst_n = 1'b0;
      #1;
      total += 7;
      if (o_valid !== 1'b0) begin bad++; $display("FAIL mid_o_valid got %b want 0", o_valid); end
      if (o_data !== '0) begin bad++; $display("FAIL mid_o_data got %0h want 0", o_data); end
      if (o_last !== 1'b0) begin bad++; $display("FAIL mid_o_last got %b want 0", o_last); end
      if (o_done !== 1'b0) begin bad++; $display("FAIL mid_o_done got %b want 0", o_done); end
      if (o_sel !== 1'b0) begin bad++; $display("FAIL mid_o_sel got %b want 0", o_sel); end
      if (o_err !== 1'b0) begin bad++; $display("FAIL mid_o_err got %b want 0", o_err); end
      if (in_ready !== 1'b1) begin bad++; $display("FAIL mid_in_ready got %b want 1", in_ready); end
      ka = '{default: 1'b0}; ks = '{default: 1'b0};
      @(posedge clk); #1 rst_n = 1'b1;
      done_seen = 0;
      for (int c = 0; c < 20; c++) begin
         @(posedge clk); #1;
         if (o_done === 1'b1 || o_valid === 1'b1) done_seen++;
      end
      total += 1;
      if (done_seen != 0) begin bad++; $display("FAIL mid_spurious_out got %0d want 0", done_seen); end
      do_fill(N, N, 1'b0, 1'b0);
      collect(0, 1'b0);
      fm = first_mismatch(1'b0);
      total += 2;
      if (fm != -1 || obs_q.size() != int'(N)) begin bad++; $display("FAIL mid_clean_word got bad index %0d count %0d", fm, obs_q.size()); end
      if (o_err !== 1'b0) begin bad++; $display("FAIL mid_clean_err got %b want 0", o_err); end
   endtask

   initial begin
      rst_n = 1'b0; fifo_wr_en_a = 0; fifo_wr_en_sub = 0; cal_done = 0; cal_sign = 0;
      fifo_wr_data_a = '0; fifo_wr_data_sub = '0; o_ready = 1'b1;
      ka = '{default: 1'b0}; ks = '{default: 1'b0};
      #2;
      test_reset();
      @(posedge clk); #1 rst_n = 1'b1;
      test_select(1'b1, 1'b1);
      test_select(1'b0, 1'b1);
      test_select(1'b1, 1'b0);
      test_backpressure();
      test_back_to_back();
      test_short_fill();
      test_write_in_drain();
      test_overflow();
      test_reset_mid_drain();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/iddmm_result_reader.md
# iddmm_result_reader

Consumer end of the IDDMM result path. Captures the two per-word result streams written by the Montgomery calculation core: the unreduced result words (`a` stream) and the result-minus-modulus words (`sub` stream). On `cal_done` it latches `cal_sign`, selects the correct stream, and drains exactly N words downstream over a valid/ready handshake, least-significant word first. It sits between the IDDMM core and the exponentiation/Paillier top level, and replaces the external FIFOs that the core's write ports otherwise feed.

## Interface
Parameters:
- `K`, 256, bits per word.
- `N`, 16, words per operand.
- `ADDR_W`, `$clog2(N)`, word index width.

Ports:
- `clk`  in  1  clock.
- `rst_n`  in  1  reset, asynchronous, active-low.
- `fifo_wr_en_a`  in  1  write strobe, unreduced result word.
- `fifo_wr_data_a`  in  K  unreduced result word.
- `fifo_wr_en_sub`  in  1  write strobe, subtracted result word.
- `fifo_wr_data_sub`  in  K  subtracted result word.
- `cal_done`  in  1  one-cycle pulse: calculation complete; `cal_sign` is valid this cycle.
- `cal_sign`  in  1  1 = take `sub` stream, 0 = take `a` stream.
- `in_ready`  out  1  block is in FILL and can accept a new operation; the scheduler launches the core only while this is high.
- `o_valid`  out  1  output word valid.
- `o_ready`  in  1  downstream accepts the word.
- `o_data`  out  K  output word; forced to 0 when `o_valid` = 0.
- `o_last`  out  1  marks word N-1, qualified by `o_valid`.
- `o_done`  out  1  one-cycle pulse after the last word is accepted.
- `o_sel`  out  1  latched `cal_sign` of the current or last operation.
- `o_err`  out  1  sticky protocol error; cleared only by reset.

## Operation
- Two buffers, each N×K, with a write pointer `wp` (width ADDR_W+1). Each strobe writes `mem[wp]` and increments `wp`. A write with `wp == N` is dropped and sets `o_err`.
- FSM states:
  - **S_FILL**: both buffers accept writes. When `cal_done` = 1, latch `o_sel <= cal_sign`, clear `rd_ptr`, and go to S_DRAIN. A write in the same cycle as `cal_done` is stored; this is the normal case for the last `sub` word.
  - **S_DRAIN**: `o_valid` = 1 and `o_data = mem_sel[rd_ptr]`. On `o_valid & o_ready`, `rd_ptr` increments. `o_last = (rd_ptr == N-1)`. When the last word is accepted, go to S_CLEAR.
  - **S_CLEAR**: one cycle. Clear both `wp` to 0, pulse `o_done`, go to S_FILL.
- If either buffer's `wp != N` when `cal_done` is sampled, set `o_err`. The drain still emits N words, including any stale contents.
- Protocol errors that set `o_err` and are otherwise ignored:
  - a write strobe outside S_FILL (the data is dropped);
  - `cal_done` outside S_FILL.
- The unselected buffer is never read; it is discarded in S_CLEAR.
- While `o_valid` = 1 and `o_ready` = 0, `o_data` and `o_last` hold stable.
- Reset mid-operation returns the block to S_FILL, clears pointers, and loses any partial data; no `o_done` is generated.

## Timing
- Reset values:
  - `in_ready` = 1;
  - `o_valid`, `o_data`, `o_last`, `o_done`, `o_sel`, `o_err` = 0;
  - state = S_FILL.
- With `cal_done` at cycle t and `o_ready` held at 1:
  - word 0 appears at t+1, word i at t+1+i;
  - `o_last` at t+N;
  - `o_done` at t+N+1;
  - `in_ready` low from t+1 through t+N+1, high again at t+N+2.
- Backpressure extends S_DRAIN by one cycle per stalled cycle. There is no other latency.
- `o_data` is a mux from registered storage, with no RAM read latency. `o_valid`, `o_last` and `o_done` are registered or derived from state only.

## Structure
- Shared package `iddmm_pkg`:
  - defaults for `K` and `N`;
  - the state enum `{S_FILL, S_DRAIN, S_CLEAR}`.
- Sub-module `iddmm_word_buf`: an N×K register buffer with write strobe, a `wp` counter, an overflow flag output, a synchronous clear, and a combinational read port indexed by `rd_ptr`. It is instantiated twice, once for `a` and once for `sub`.
- The top level holds the FSM, `rd_ptr`, `o_sel`, the error logic and the output mux.

## Test plan
- **Sub selected.** Write N `a` words 0xA00+i, then N `sub` words 0x500+i, with the last `sub` write coincident with `cal_done`, `cal_sign` = 1, `o_ready` = 1. Expect 0x500..0x50F on t+1..t+16, `o_last` at t+16, `o_done` at t+17, `o_sel` = 1, `o_err` = 0.
- **A selected.** Same stimulus with `cal_sign` = 0. Expect 0xA00..0xA0F streamed and `o_sel` = 0.
- **Backpressure.** Toggle `o_ready` 1,0,0,1,… during the drain. Expect each word held stable while stalled, the 16 words delivered in order with none dropped or duplicated, and `o_done` exactly one cycle after word 15 is accepted.
- **Protocol errors.**
  - Assert `cal_done` after only 15 `sub` writes: expect `o_err` = 1 and still 16 words out.
  - Issue a write strobe during S_DRAIN: expect `o_err` = 1 and that write not to appear in the next operation.
  - Issue 17 writes: expect `o_err` = 1.
- **Reset mid-drain.** Deassert `rst_n` after word 5. Expect all outputs at their reset values and `in_ready` = 1. A subsequent clean operation must stream correctly with `o_err` = 0.
- **Back-to-back operations.** Start the second fill at `in_ready` rise (t+N+2). Expect the second result correct and no residue from the first.
